// File: rtl/riscv_core.sv
// Two-cycle (FETCH/EXECUTE) RV32I core with internal ROM, register file and data RAM.
// The ROM holds a built-in program unless USE_IMAGE selects the ROM_IMAGE parameter instead.

module reg_file (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);
  logic [31:0] regFile [0:31];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      regFile[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : regFile[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : regFile[i_raddr2];
endmodule

module data_mem #(
  parameter int DMEM_BYTES = 256,
  parameter int AW = $clog2(DMEM_BYTES)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-3:0] i_word,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [7:0] ram [0:DMEM_BYTES-1];

  // Word index only: the low two address bits never reach this block.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DMEM_BYTES; i++) ram[i] <= '0;
    end else if (i_we) begin
      ram[{i_word, 2'd0}] <= i_wdata[7:0];
      ram[{i_word, 2'd1}] <= i_wdata[15:8];
      ram[{i_word, 2'd2}] <= i_wdata[23:16];
      ram[{i_word, 2'd3}] <= i_wdata[31:24];
    end
  end

  assign o_rdata = {ram[{i_word, 2'd3}], ram[{i_word, 2'd2}], ram[{i_word, 2'd1}], ram[{i_word, 2'd0}]};
endmodule

module riscv_core #(
  parameter int                     IMEM_WORDS = 64,
  parameter int                     DMEM_BYTES = 256,
  parameter bit                     USE_IMAGE  = 1'b0,
  parameter logic [IMEM_WORDS*32-1:0] ROM_IMAGE = '0
) (
  input logic CLK,
  input logic Reset
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int AW = $clog2(DMEM_BYTES);
  localparam logic [0:0]  S_FETCH = 1'b0;
  localparam logic [0:0]  S_EXEC  = 1'b1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [6:0]  OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67;
  localparam logic [6:0]  OPC_BR  = 7'h63, OPC_LD = 7'h03, OPC_ST = 7'h23, OPC_IMM = 7'h13, OPC_OP = 7'h33;

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;

  function automatic logic [31:0] default_rom(input logic [31:0] idx);
    case (idx)
      32'd0:   return 32'h0050_0093;
      32'd1:   return 32'h0030_0113;
      32'd2:   return 32'h0020_81B3;
      32'd3:   return 32'h0030_2023;
      32'd4:   return 32'h0000_2203;
      32'd5:   return 32'h0041_8463;
      32'd6:   return 32'h0000_006F;
      32'd7:   return 32'h0010_0293;
      32'd8:   return 32'h0000_006F;
      default: return NOP;
    endcase
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b, input logic sub, input logic sra);
    logic [31:0] y;
    y = '0;
    case (f3)
      3'b000: y = sub ? (a - b) : (a + b);
      3'b001: y = a << b[4:0];
      3'b010: y = {31'b0, $signed(a) < $signed(b)};
      3'b011: y = {31'b0, a < b};
      3'b100: y = a ^ b;
      // Kept as separate statements so the arithmetic shift stays in a signed context.
      3'b101: if (sra) y = $signed(a) >>> b[4:0]; else y = a >> b[4:0];
      3'b110: y = a | b;
      default: y = a & b;
    endcase
    return y;
  endfunction

  function automatic logic br_take(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  logic [IW-1:0] w_rom_idx;
  logic [31:0]   w_rom_word;
  logic [6:0]    w_opcode;
  logic [4:0]    w_rd, w_rs1, w_rs2;
  logic [2:0]    w_f3;
  logic [31:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0]   w_rs1_val, w_rs2_val, w_mem_addr, w_mem_rdata;
  logic          w_rd_we, w_mem_we, w_exec;
  logic [31:0]   w_rd_data, w_next_pc;
  logic          w_unused_addr;

  assign w_rom_idx  = r_pc[IW+1:2];
  assign w_rom_word = USE_IMAGE ? ROM_IMAGE[{w_rom_idx, 5'b0} +: 32] : default_rom(32'(w_rom_idx));

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_imm_i  = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s  = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b  = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u  = {r_ir[31:12], 12'b0};
  assign w_imm_j  = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  assign w_exec   = (r_state == S_EXEC);

  assign w_mem_addr    = w_rs1_val + ((w_opcode == OPC_ST) ? w_imm_s : w_imm_i);
  assign w_unused_addr = ^{w_mem_addr[31:AW], w_mem_addr[1:0]};

  always_comb begin
    w_rd_we   = 1'b0;
    w_rd_data = '0;
    w_mem_we  = 1'b0;
    w_next_pc = r_pc + 32'd4;
    case (w_opcode)
      OPC_LUI:   begin w_rd_we = 1'b1; w_rd_data = w_imm_u; end
      OPC_AUIPC: begin w_rd_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
      OPC_JAL: begin
        w_rd_we   = 1'b1;
        w_rd_data = r_pc + 32'd4;
        w_next_pc = r_pc + w_imm_j;
      end
      OPC_JALR: begin
        w_rd_we   = 1'b1;
        w_rd_data = r_pc + 32'd4;
        w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
      end
      OPC_BR:  if (br_take(w_f3, w_rs1_val, w_rs2_val)) w_next_pc = r_pc + w_imm_b;
      OPC_LD:  begin w_rd_we = 1'b1; w_rd_data = w_mem_rdata; end
      OPC_ST:  w_mem_we = 1'b1;
      OPC_IMM: begin
        w_rd_we   = 1'b1;
        w_rd_data = alu(w_f3, w_rs1_val, w_imm_i, 1'b0, r_ir[30]);
      end
      OPC_OP: begin
        w_rd_we   = 1'b1;
        w_rd_data = alu(w_f3, w_rs1_val, w_rs2_val, r_ir[30], r_ir[30]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= NOP;
    end else if (r_state == S_FETCH) begin
      r_ir    <= w_rom_word;
      r_state <= S_EXEC;
    end else begin
      r_pc    <= w_next_pc;
      r_state <= S_FETCH;
    end
  end

  reg_file reg_file (
    .i_clk(CLK), .i_rst(Reset), .i_we(w_rd_we && w_exec), .i_waddr(w_rd), .i_wdata(w_rd_data),
    .i_raddr1(w_rs1), .i_raddr2(w_rs2), .o_rdata1(w_rs1_val), .o_rdata2(w_rs2_val)
  );

  data_mem #(.DMEM_BYTES(DMEM_BYTES)) data_mem (
    .i_clk(CLK), .i_rst(Reset), .i_we(w_mem_we && w_exec), .i_word(w_mem_addr[AW-1:2]),
    .i_wdata(w_rs2_val), .o_rdata(w_mem_rdata)
  );
endmodule

// File: tb/tb_riscv_core.sv
// Bench for riscv_core: built-in program, asynchronous mid-run reset, and an alternate ROM
// exercising x0, SUB/SRA/SLTU/BLT, JAL/JALR and an unaligned SW/LW pair.
module tb_riscv_core;
  localparam int          IMEM_WORDS = 64;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [IMEM_WORDS*32-1:0] build_alt();
    logic [IMEM_WORDS*32-1:0] img;
    for (int k = 0; k < IMEM_WORDS; k++) img[k*32 +: 32] = NOP;
    img[0*32 +: 32]  = enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'h13);      // addi x0,x0,7
    img[1*32 +: 32]  = enc_i(12'd9, 5'd0, 3'b000, 5'd6, 7'h13);      // addi x6,x0,9
    img[2*32 +: 32]  = enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'h13);
    img[3*32 +: 32]  = enc_i(12'd5, 5'd0, 3'b000, 5'd2, 7'h13);
    img[4*32 +: 32]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3);       // sub x3,x1,x2
    img[5*32 +: 32]  = {20'h80000, 5'd4, 7'h37};                     // lui x4,0x80000
    img[6*32 +: 32]  = enc_i(12'd4, 5'd0, 3'b000, 5'd7, 7'h13);
    img[7*32 +: 32]  = enc_r(7'h20, 5'd7, 5'd4, 3'b101, 5'd5);       // sra x5,x4,x7
    img[8*32 +: 32]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd8, 7'h13);    // x8 = -1
    img[9*32 +: 32]  = enc_i(12'd1, 5'd0, 3'b000, 5'd9, 7'h13);
    img[10*32 +: 32] = enc_r(7'h00, 5'd8, 5'd9, 3'b011, 5'd10);      // sltu x10,x9,x8
    img[11*32 +: 32] = enc_b(13'd8, 5'd1, 5'd8, 3'b100);             // blt x8,x1,+8
    img[12*32 +: 32] = enc_i(12'd1, 5'd0, 3'b000, 5'd11, 7'h13);
    img[13*32 +: 32] = enc_j(21'd12, 5'd12);                          // jal x12,+12
    img[14*32 +: 32] = enc_i(12'd2, 5'd0, 3'b000, 5'd11, 7'h13);
    img[15*32 +: 32] = enc_i(12'd3, 5'd0, 3'b000, 5'd11, 7'h13);
    img[16*32 +: 32] = enc_i(12'h051, 5'd0, 3'b000, 5'd13, 7'h13);
    img[17*32 +: 32] = enc_i(12'd0, 5'd13, 3'b000, 5'd14, 7'h67);    // jalr x14,0(x13)
    img[18*32 +: 32] = enc_i(12'd4, 5'd0, 3'b000, 5'd11, 7'h13);
    img[20*32 +: 32] = enc_i(12'h013, 5'd0, 3'b000, 5'd15, 7'h13);
    img[21*32 +: 32] = enc_s(12'd0, 5'd3, 5'd15);                     // sw x3,0(x15)
    img[22*32 +: 32] = enc_i(12'h010, 5'd0, 3'b010, 5'd16, 7'h03);   // lw x16,0x10(x0)
    img[23*32 +: 32] = enc_j(21'd0, 5'd0);
    return img;
  endfunction

  localparam logic [IMEM_WORDS*32-1:0] ALT_IMG = build_alt();

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_alt = 1'b1;
  always #5 clk = ~clk;

  riscv_core dut (.CLK(clk), .Reset(rst));
  riscv_core #(.IMEM_WORDS(IMEM_WORDS), .DMEM_BYTES(256), .USE_IMAGE(1'b1), .ROM_IMAGE(ALT_IMG))
    dut_alt (.CLK(clk), .Reset(rst_alt));

  // Scoreboard
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          failures = 0;

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%08h expected=none", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", t, obs, e);
    end
  endtask

  // Driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_main();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_default_final();
    for (int i = 0; i < 32; i++)
      push_exp($sformatf("def_x%0d", i), (i == 1) ? 32'd5 : (i == 2) ? 32'd3 : (i == 3) ? 32'd8 :
                                         (i == 4) ? 32'd8 : (i == 5) ? 32'd1 : 32'd0);
    push_exp("def_ram0", 32'h08);
    for (int i = 1; i < 4; i++) push_exp($sformatf("def_ram%0d", i), 32'h00);
  endtask

  task automatic check_main_arch();
    for (int i = 0; i < 32; i++) pop_check(dut.reg_file.regFile[i]);
    for (int i = 0; i < 4; i++) pop_check({24'h0, dut.data_mem.ram[i]});
  endtask

  task automatic run_default_trace();
    logic [31:0] trace [10];
    trace = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C, 32'h20, 32'h20, 32'h20, 32'h20};
    for (int i = 0; i < 10; i++) push_exp($sformatf("def_pc_after_instr%0d", i), trace[i]);
    for (int i = 0; i < 10; i++) begin
      cycles(2);
      pop_check(dut.r_pc);
    end
  endtask

  task automatic check_main_in_reset(input string phase);
    push_exp({phase, "_pc"}, 32'h0);
    push_exp({phase, "_state"}, 32'h0);
    push_exp({phase, "_ir"}, NOP);
    for (int i = 0; i < 32; i++) push_exp($sformatf("%s_x%0d", phase, i), 32'h0);
    for (int i = 0; i < 4; i++) push_exp($sformatf("%s_ram%0d", phase, i), 32'h0);
    pop_check(dut.r_pc);
    pop_check({31'b0, dut.r_state});
    pop_check(dut.r_ir);
    check_main_arch();
  endtask

  initial begin
    logic [31:0] alt_trace [20];
    logic [31:0] alt_regs [32];

    // Reset held for 12 ns
    #11;
    check_main_in_reset("por");
    #1 rst = 1'b0;

    // First fetch at the first rising edge, first commit at the second
    push_exp("fetch_state", 32'h1);
    push_exp("fetch_ir", 32'h0050_0093);
    cycles(1);
    pop_check({31'b0, dut.r_state});
    pop_check(dut.r_ir);
    push_exp("instr0_pc", 32'h04);
    push_exp("instr0_x1", 32'h05);
    cycles(1);
    pop_check(dut.r_pc);
    pop_check(dut.reg_file.regFile[1]);
    for (int i = 0; i < 9; i++) begin
      cycles(2);
    end
    push_default_final();
    check_main_arch();
    push_exp("halt_pc", 32'h20);
    pop_check(dut.r_pc);

    // Asynchronous reset while halted, then a run interrupted at cycle 7
    rst = 1'b1;
    #1;
    check_main_in_reset("halted_rst");
    release_main();
    cycles(7);
    rst = 1'b1;
    #1;
    check_main_in_reset("midrun_rst");
    release_main();
    run_default_trace();
    push_default_final();
    check_main_arch();

    // Alternate ROM
    alt_trace = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28,
                  32'h2C, 32'h34, 32'h40, 32'h44, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h5C, 32'h5C};
    for (int i = 0; i < 32; i++) alt_regs[i] = 32'h0;
    alt_regs[1] = 32'h3;          alt_regs[2] = 32'h5;          alt_regs[3] = 32'hFFFF_FFFE;
    alt_regs[4] = 32'h8000_0000;  alt_regs[5] = 32'hF800_0000;  alt_regs[6] = 32'h9;
    alt_regs[7] = 32'h4;          alt_regs[8] = 32'hFFFF_FFFF;  alt_regs[9] = 32'h1;
    alt_regs[10] = 32'h1;         alt_regs[12] = 32'h38;        alt_regs[13] = 32'h51;
    alt_regs[14] = 32'h48;        alt_regs[15] = 32'h13;        alt_regs[16] = 32'hFFFF_FFFE;

    @(negedge clk);
    rst_alt = 1'b0;
    for (int i = 0; i < 20; i++) push_exp($sformatf("alt_pc_after_instr%0d", i), alt_trace[i]);
    for (int i = 0; i < 20; i++) begin
      cycles(2);
      pop_check(dut_alt.r_pc);
    end
    for (int i = 0; i < 32; i++) push_exp($sformatf("alt_x%0d", i), alt_regs[i]);
    for (int i = 0; i < 32; i++) pop_check(dut_alt.reg_file.regFile[i]);
    push_exp("alt_ram10", 32'hFE);
    push_exp("alt_ram11", 32'hFF);
    push_exp("alt_ram12", 32'hFF);
    push_exp("alt_ram13", 32'hFF);
    push_exp("alt_ram14", 32'h00);
    push_exp("alt_ram0F", 32'h00);
    for (int i = 16; i < 21; i++) pop_check({24'h0, dut_alt.data_mem.ram[i]});
    pop_check({24'h0, dut_alt.data_mem.ram[15]});

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
